acquisition_sequencer: RTL and testbench

Sequences the photon-counting acquisition: it opens fixed-length integration windows, commands the I/Q counters to latch, and reads the gated-waveform histogram bins out over a valid/ready stream. It clears each bin as that bin is read, then either re-arms or goes idle. It sits between the 50 MHz counting/histogram datapath, which owns the bin RAM write port during integration, and the readout/probe path. The block grants the bin RAM to itself only while integration is disabled.

---
 rtl/acquisition_sequencer.sv | 154 +++++++++++++++
 tb/tb_acquisition_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acquisition_sequencer.sv
// Photon-counting acquisition sequencer: integration window timing, I/Q latch
// command, and histogram bin readout with read-then-clear over a valid/ready stream.
module acquisition_sequencer #(
  parameter logic [31:0] INTEGRATION_CYCLES = 32'd500000000,
  parameter int          NUM_BINS           = 40,
  parameter int          AW                 = $clog2(NUM_BINS)
) (
  input  logic          clock_50_mhz,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          continuous,
  output logic          integrate_en,
  output logic          latch_pulse,
  output logic          bin_rd_en,
  output logic [AW-1:0] bin_addr,
  input  logic [31:0]   bin_rd_data,
  output logic          bin_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [AW-1:0] out_index,
  output logic          out_last,
  output logic [31:0]   frame_count,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE, INTEGRATE, LATCH, RD_REQ, RD_WAIT, PRESENT, FLUSH
  } state_t;

  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_BINS - 1);
  localparam logic [31:0]   TIMER_END = INTEGRATION_CYCLES - 32'd1;

  state_t          state_q, state_d;
  logic [31:0]     timer_q, timer_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            stop_pend_q, stop_pend_d;
  logic [31:0]     frame_q, frame_d;
  logic [31:0]     data_q, data_d;
  logic            ie_q, lp_q, rd_en_q, flush_clr_q, valid_q, last_q, busy_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    stop_pend_d = stop_pend_q;
    frame_d     = frame_q;
    data_d      = data_q;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = INTEGRATE;
          timer_d = '0;
        end
      end
      INTEGRATE: begin
        if (stop) begin
          state_d = FLUSH;
          idx_d   = '0;
        end else if (timer_q == TIMER_END) begin
          state_d = LATCH;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      LATCH: begin
        if (stop) stop_pend_d = 1'b1;
        idx_d   = '0;
        state_d = RD_REQ;
      end
      RD_REQ: begin
        if (stop) stop_pend_d = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (stop) stop_pend_d = 1'b1;
        data_d  = bin_rd_data;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (stop) stop_pend_d = 1'b1;
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            frame_d = frame_q + 32'd1;
            // A stop arriving on the final accept still prevents re-arming.
            if (continuous && !stop_pend_q && !stop) begin
              state_d = INTEGRATE;
              timer_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      FLUSH: begin
        if (idx_q == LAST_IDX) state_d = IDLE;
        else                   idx_d   = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE && state_q != IDLE) stop_pend_d = 1'b0;
  end

  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      stop_pend_q <= 1'b0;
      frame_q     <= '0;
      data_q      <= '0;
      ie_q        <= 1'b0;
      lp_q        <= 1'b0;
      rd_en_q     <= 1'b0;
      flush_clr_q <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      stop_pend_q <= stop_pend_d;
      frame_q     <= frame_d;
      data_q      <= data_d;
      // Strobes are decoded from the next state so each one is a clean flop output.
      ie_q        <= (state_d == INTEGRATE);
      lp_q        <= (state_d == LATCH);
      rd_en_q     <= (state_d == RD_REQ);
      flush_clr_q <= (state_d == FLUSH);
      valid_q     <= (state_d == PRESENT);
      last_q      <= (state_d == PRESENT) && (idx_d == LAST_IDX);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign integrate_en = ie_q;
  assign latch_pulse  = lp_q;
  assign bin_rd_en    = rd_en_q;
  assign bin_addr     = idx_q;
  // The read-clear must land on the accept cycle itself, so it follows out_ready.
  assign bin_clr      = flush_clr_q | (valid_q & out_ready);
  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign out_index    = idx_q;
  assign out_last     = last_q;
  assign frame_count  = frame_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Directed bench for acquisition_sequencer with a bin RAM model and a stream scoreboard.
module tb_acquisition_sequencer;

  localparam int AW = 2;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [31:0]   data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0, stop = 1'b0, continuous = 1'b0, out_ready = 1'b1;
  logic          integrate_en, latch_pulse, bin_rd_en, bin_clr, out_valid, out_last, busy;
  logic [AW-1:0] bin_addr, out_index;
  logic [31:0]   bin_rd_data, out_data, frame_count;

  logic [31:0] ram [4];
  logic [31:0] pre [4];
  logic        pl_req = 1'b0;

  int vectors = 0, miscompares = 0;
  int ie_cnt = 0, lp_cnt = 0, extra = 0;
  logic viol_arb = 1'b0, viol_last = 1'b0, viol_stab = 1'b0;
  logic stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic [AW-1:0] prev_idx;
  int clr_q [$];
  beat_t exp_q [$];
  beat_t mon_e;

  acquisition_sequencer #(.INTEGRATION_CYCLES(32'd10), .NUM_BINS(4)) dut (
    .clock_50_mhz(clk), .reset_n(rst_n), .start(start), .stop(stop),
    .continuous(continuous), .integrate_en(integrate_en), .latch_pulse(latch_pulse),
    .bin_rd_en(bin_rd_en), .bin_addr(bin_addr), .bin_rd_data(bin_rd_data),
    .bin_clr(bin_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bin RAM: registered read, write-zero on clear, bench-side preload.
  always @(posedge clk) begin
    if (pl_req) for (int i = 0; i < 4; i++) ram[i] <= pre[i];
    else if (bin_clr) ram[bin_addr] <= 32'd0;
    if (bin_rd_en) bin_rd_data <= ram[bin_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (integrate_en) ie_cnt++;
      if (latch_pulse) lp_cnt++;
      if (bin_clr) clr_q.push_back(int'(bin_addr));
      if (integrate_en && (bin_rd_en || bin_clr)) viol_arb = 1'b1;
      if (out_last && !(out_valid && out_index == 2'd3)) viol_last = 1'b1;
      if (stall_prev && (!out_valid || out_data != prev_data || out_index != prev_idx))
        viol_stab = 1'b1;
      if (out_valid && !out_ready && bin_clr) viol_stab = 1'b1;
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_index;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) extra++;
        else begin
          mon_e = exp_q.pop_front();
          chk("beat", {out_index, out_data, out_last}, mon_e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, b, c, d);
    pre[0] = a; pre[1] = b; pre[2] = c; pre[3] = d;
    pl_req = 1'b1;
    tick(1);
    pl_req = 1'b0;
  endtask

  task automatic push_frame(input logic [31:0] a, b, c, d);
    exp_q.push_back({2'd0, a, 1'b0});
    exp_q.push_back({2'd1, b, 1'b0});
    exp_q.push_back({2'd2, c, 1'b0});
    exp_q.push_back({2'd3, d, 1'b1});
  endtask

  task automatic clear_mon();
    ie_cnt = 0; lp_cnt = 0; extra = 0;
    clr_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      tick(1);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic check_frame_end(input string tag, input int ie_exp, input int lp_exp);
    chk({tag, "_ie_cycles"}, ie_cnt, ie_exp);
    chk({tag, "_latches"}, lp_cnt, lp_exp);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_extra"}, extra, 0);
    chk({tag, "_clr_n"}, clr_q.size(), 4);
    for (int i = 0; i < clr_q.size(); i++) chk({tag, "_clr_addr"}, clr_q[i], i);
    for (int i = 0; i < 4; i++) chk({tag, "_ram_zero"}, ram[i], 0);
    chk({tag, "_viol"}, {viol_arb, viol_last, viol_stab}, 3'b000);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_strobes"},
        {integrate_en, latch_pulse, bin_rd_en, bin_clr, out_valid, out_last, busy}, 7'd0);
    chk({tag, "_addr_idx"}, {bin_addr, out_index}, 4'd0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_frames"}, frame_count, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 check_reset_outs("reset");
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Single frame
    preload(32'd5, 32'd0, 32'd7, 32'd9);
    push_frame(32'd5, 32'd0, 32'd7, 32'd9);
    clear_mon();
    pulse_start();
    chk("s1_ie_rise", integrate_en, 1);
    wait_idle("s1_idle");
    check_frame_end("s1", 10, 1);
    chk("s1_frames", frame_count, 1);

    // Backpressure on bin 2, plus a start during readout
    preload(32'd5, 32'd0, 32'd7, 32'd9);
    push_frame(32'd5, 32'd0, 32'd7, 32'd9);
    clear_mon();
    pulse_start();
    for (int i = 0; i < 100 && !(out_valid && out_index == 2'd2); i++) tick(1);
    chk("s2_reach_bin2", {out_valid, out_index}, 3'b110);
    out_ready = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    chk("s2_hold", {out_valid, out_index, out_data, bin_clr}, {1'b1, 2'd2, 32'd7, 1'b0});
    tick(1);
    out_ready = 1'b1;
    wait_idle("s2_idle");
    check_frame_end("s2", 10, 1);
    chk("s2_frames", frame_count, 2);
    tick(3);
    chk("s2_stays_idle", {busy, integrate_en}, 2'b00);

    // Continuous mode, stop during bin 1
    continuous = 1'b1;
    preload(32'd1, 32'd2, 32'd3, 32'd4);
    push_frame(32'd1, 32'd2, 32'd3, 32'd4);
    clear_mon();
    pulse_start();
    for (int i = 0; i < 100 && !(out_valid && out_index == 2'd1); i++) tick(1);
    chk("s3_reach_bin1", {out_valid, out_index}, 3'b101);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    wait_idle("s3_idle");
    check_frame_end("s3", 10, 1);
    chk("s3_frames", frame_count, 3);
    tick(3);
    chk("s3_no_rearm", {busy, integrate_en}, 2'b00);
    continuous = 1'b0;

    // Abort at integration cycle 5
    preload(32'd8, 32'd8, 32'd8, 32'd8);
    clear_mon();
    pulse_start();
    tick(4);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("s4_abort", {integrate_en, bin_clr, bin_addr}, {1'b0, 1'b1, 2'd0});
    wait_idle("s4_idle");
    chk("s4_ie_cycles", ie_cnt, 5);
    chk("s4_latches", lp_cnt, 0);
    chk("s4_extra", extra, 0);
    chk("s4_clr_n", clr_q.size(), 4);
    for (int i = 0; i < clr_q.size(); i++) chk("s4_clr_addr", clr_q[i], i);
    for (int i = 0; i < 4; i++) chk("s4_ram_zero", ram[i], 0);
    chk("s4_frames", frame_count, 3);

    // Simultaneous start and stop in IDLE
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    chk("s5_busy", busy, 0);
    tick(2);
    chk("s5_ie", integrate_en, 0);

    // Reset pulsed during PRESENT, then a normal frame
    preload(32'd1, 32'd2, 32'd3, 32'd4);
    clear_mon();
    pulse_start();
    for (int i = 0; i < 100 && !out_valid; i++) tick(1);
    chk("s6_present", {out_valid, out_index, out_data}, {1'b1, 2'd0, 32'd1});
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outs("s6_async_reset");
    tick(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(1);
    push_frame(32'd1, 32'd2, 32'd3, 32'd4);
    clear_mon();
    pulse_start();
    wait_idle("s6_idle");
    check_frame_end("s6", 10, 1);
    chk("s6_frames", frame_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
